mmio_uart_sink: RTL and testbench
=================================

// Module: mmio_uart_sink
// PURPOSE
//   Responder end of the core's store port (m_addr/m_data/wea). Decodes store
//   writes into a small MMIO space: a byte-wide TX data register feeding a FIFO
//   drained by an 8N1 UART transmitter, an LED output register, and an
//   overflow-clear register. Sits at top level beside tinyrv32.
// PARAMETERS
//   CLK_DIV     868           clk cycles per UART bit (100 MHz / 115200); min 2
//   FIFO_DEPTH  16            TX FIFO entries, power of two, >= 2
//   TX_ADDR     32'h0000_8000 store here pushes m_data[7:0] into TX FIFO
//   LED_ADDR    32'h0000_8004 store here loads led <= m_data[7:0]
//   CLR_ADDR    32'h0000_8008 any store here clears overflow
// PORTS
//   clk       in   1   system clock, all state on posedge
//   rst       in   1   asynchronous, active-high reset
//   m_addr    in   32  store address from core
//   m_data    in   32  store data from core (only [7:0] used)
//   wea       in   1   store-valid level from core
//   wr_tick   in   1   one-clk pulse per core write phase; qualifies wea
//   tx        out  1   UART serial out, idle high
//   led       out  8   LED register
//   busy      out  1   FIFO non-empty or frame in flight
//   overflow  out  1   sticky: a TX push was dropped
// BEHAVIOUR
//   - Reset (async, any time incl. mid-frame): tx=1, led=0, busy=0, overflow=0,
//     FIFO pointers/count=0 (contents discarded), FSM=IDLE, bit/baud ctrs=0.
//   - Write accepted only on a clk edge where wr_tick & wea; wea without
//     wr_tick is ignored (wea holds across core cycles). Full 32-bit address
//     compare; unmatched addresses ignored, no error.
//   - TX_ADDR push: entry visible (count+1) the cycle after acceptance.
//     LED_ADDR: led updates the cycle after acceptance. CLR_ADDR: overflow=0
//     the cycle after.
//   - FIFO full and push with no pop the same cycle: byte dropped, overflow=1,
//     count unchanged. Full with push and pop the same cycle: both happen,
//     count stays FIFO_DEPTH, no overflow. Pointers wrap modulo FIFO_DEPTH;
//     count is $clog2(FIFO_DEPTH)+1 bits.
//   - CLR_ADDR and a dropped push in the same cycle cannot occur (one address
//     per write); overflow set has priority over nothing else.
//   - TX FSM: IDLE -> START when count!=0; pop occurs in the IDLE->START cycle
//     and the byte is latched into a shift register.
//     START (tx=0, CLK_DIV clks) -> DATA (8 bits LSB first, CLK_DIV clks each)
//     -> [PARITY] -> STOP (tx=1, CLK_DIV clks) -> IDLE.
//     Frame = 10*CLK_DIV clks (11*CLK_DIV with parity). First start bit
//     drives tx the cycle after the FSM leaves IDLE.
//   - STOP -> IDLE -> START back-to-back: exactly one IDLE clk between frames
//     (tx=1 during it).
//   - tx is registered, glitch-free. busy = (FSM!=IDLE) | (count!=0), combin.
// CONFIGURATION
//   MMIO_UART_PARITY_EN defined: PARITY state inserted after DATA, one bit
//     time, tx = ^byte (even parity); frame 11*CLK_DIV clks.
//   Undefined: no PARITY state, 8N1, frame 10*CLK_DIV clks.
// TESTING  (bench uses CLK_DIV=4, FIFO_DEPTH=4)
//   1 rst; wea=1,wr_tick=1,m_addr=8000,m_data=0x41 -> tx low 4 clks, bits
//     1,0,0,0,0,0,1,0 each 4 clks, high 4 clks; frame 40 clks; busy then 0.
//   2 wea=1 held 20 clks, wr_tick pulses twice, addr 8000 data 0x55 -> exactly
//     2 frames of 0x55; wea without wr_tick pushes nothing.
//   3 6 pushes 0x01..0x06 on consecutive ticks while idle -> first popped
//     immediately; 0x01..0x05 sent, 0x06 dropped, overflow=1; store to 8008
//     -> overflow=0 next cycle.
//   4 store 8004 data 0xA5 -> led=0xA5 next cycle; store 9000 -> no change.
//   5 rst asserted mid-DATA of frame 1 with 2 queued -> tx=1 same cycle,
//     busy=0, no further frames after release.
//   6 MMIO_UART_PARITY_EN, push 0x07 -> parity bit 1, frame 44 clks; 0x03 -> 0.

Source files
------------

// File: rtl/mmio_uart_sink.sv
// MMIO store sink: TX byte FIFO drained by a UART transmitter, LED register, sticky overflow flag.
// Define MMIO_UART_PARITY_EN for an even-parity bit after the data bits (8E1); default is 8N1.
module mmio_uart_sink #(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] TX_ADDR    = 32'h0000_8000,
    parameter logic [31:0] LED_ADDR   = 32'h0000_8004,
    parameter logic [31:0] CLR_ADDR   = 32'h0000_8008
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_data,
    input  logic        wea,
    input  logic        wr_tick,
    output logic        tx,
    output logic [7:0]  led,
    output logic        busy,
    output logic        overflow
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLK_DIV);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic [7:0]          led_q, led_d;
    logic                ovf_q, ovf_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          mem [FIFO_DEPTH];
`ifdef MMIO_UART_PARITY_EN
    logic                par_q, par_d;
`endif

    logic accept, push_req, clr_req, led_req, full, push, pop, baud_end;
    logic unused_c;

    assign unused_c = ^m_data[31:8];
    assign accept   = wr_tick & wea;
    assign push_req = accept && (m_addr == TX_ADDR);
    assign led_req  = accept && (m_addr == LED_ADDR);
    assign clr_req  = accept && (m_addr == CLR_ADDR);
    assign full     = (cnt_q == CNT_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push
    assign push     = push_req && (!full || pop);
    assign baud_end = (baud_q == BAUD_W'(CLK_DIV - 1));

    // TX framing FSM: next state, shift register and registered tx value
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef MMIO_UART_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cnt_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
`ifdef MMIO_UART_PARITY_EN
                    par_d   = ^mem[rd_ptr_q];
`endif
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef MMIO_UART_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // tx follows the state being entered so the line changes on the transition edge
        tx_d = 1'b1;
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef MMIO_UART_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // FIFO pointers/count, LED and overflow next state
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        led_d = led_req ? m_data[7:0] : led_q;
        ovf_d = ovf_q;
        if (push_req && !push) begin
            ovf_d = 1'b1;
        end else if (clr_req) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            led_q    <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
`ifdef MMIO_UART_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            led_q    <= led_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
`ifdef MMIO_UART_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    // FIFO storage carries no reset; stale contents are unreachable once pointers clear
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= m_data[7:0];
        end
    end

    assign tx       = tx_q;
    assign led      = led_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != S_IDLE) || (cnt_q != '0);

endmodule

// File: tb/tb_mmio_uart_sink.sv
// Directed bench for mmio_uart_sink (CLK_DIV=4, FIFO_DEPTH=4); a UART receiver model decodes tx.
module tb_mmio_uart_sink;

    localparam int unsigned DIV = 4;
`ifdef MMIO_UART_PARITY_EN
    localparam int unsigned NB = 11;
`else
    localparam int unsigned NB = 10;
`endif
    localparam logic [31:0] A_TX  = 32'h0000_8000;
    localparam logic [31:0] A_LED = 32'h0000_8004;
    localparam logic [31:0] A_CLR = 32'h0000_8008;

    logic        clk, rst, wea, wr_tick;
    logic [31:0] m_addr, m_data;
    logic        tx, busy, overflow;
    logic [7:0]  led;

    int n_pass = 0;
    int n_total = 0;
    int rx_err = 0;
    logic [7:0] rx_q[$];

    mmio_uart_sink #(
        .CLK_DIV   (DIV),
        .FIFO_DEPTH(4),
        .TX_ADDR   (A_TX),
        .LED_ADDR  (A_LED),
        .CLR_ADDR  (A_CLR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_addr  (m_addr),
        .m_data  (m_data),
        .wea     (wea),
        .wr_tick (wr_tick),
        .tx      (tx),
        .led     (led),
        .busy    (busy),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        m_addr  = addr;
        m_data  = data;
        wea     = 1'b1;
        wr_tick = 1'b1;
        tick();
        wr_tick = 1'b0;
        wea     = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && busy !== 1'b0; i++) tick();
        tick();
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] rx_at(input int i);
        if (i < rx_q.size()) return 32'(rx_q[i]);
        return 32'hxxxx_xxxx;
    endfunction

    // Cycle-exact frame check: waits for the start bit then compares tx on every clock
    task automatic expect_frame(input string tag, input logic [7:0] b);
        logic [10:0] bits;
`ifdef MMIO_UART_PARITY_EN
        bits = {1'b1, ^b, b, 1'b0};
`else
        bits = {1'b1, 1'b1, b, 1'b0};
`endif
        for (int i = 0; i < 300 && tx !== 1'b0; i++) tick();
        check({tag, "_start_seen"}, 32'(tx), 32'd0);
        for (int k = 0; k < int'(NB * DIV); k++) begin
            check($sformatf("%s_bit%0d_clk%0d", tag, k / DIV, k % DIV), 32'(tx), 32'(bits[k / DIV]));
            tick();
        end
        check({tag, "_after"}, 32'(tx), 32'd1);
    endtask

    // Receiver model: samples mid-bit on falling clock edges; frames cut by reset are discarded
    initial begin
        logic [7:0] b;
        logic ok, abort;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                ok = 1'b1;
                abort = 1'b0;
                b = '0;
                @(negedge clk);
                if (rst) abort = 1'b1;
                if (tx !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    for (int j = 0; j < int'(DIV); j++) begin
                        @(negedge clk);
                        if (rst) abort = 1'b1;
                    end
                    b[i] = tx;
                end
`ifdef MMIO_UART_PARITY_EN
                for (int j = 0; j < int'(DIV); j++) begin
                    @(negedge clk);
                    if (rst) abort = 1'b1;
                end
                if (tx !== ^b) ok = 1'b0;
`endif
                for (int j = 0; j < int'(DIV); j++) begin
                    @(negedge clk);
                    if (rst) abort = 1'b1;
                end
                if (tx !== 1'b1) ok = 1'b0;
                for (int j = 0; j < 2; j++) begin
                    @(negedge clk);
                    if (rst) abort = 1'b1;
                end
                if (!abort) begin
                    rx_q.push_back(b);
                    if (!ok) rx_err++;
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        wea = 1'b0;
        wr_tick = 1'b0;
        m_addr = '0;
        m_data = '0;
        repeat (3) tick();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_led", 32'(led), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // 1: single byte, exact waveform
        store(A_TX, 32'hFFFF_FF41);
        check("t1_busy_after_push", 32'(busy), 32'd1);
        expect_frame("t1", 8'h41);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_rx_n", 32'(rx_q.size()), 32'd1);
        check("t1_rx0", rx_at(0), 32'h41);
        rx_q.delete();

        // 2: wea held, only wr_tick pulses push
        m_addr = A_TX;
        m_data = 32'h0000_0055;
        wea = 1'b1;
        for (int c = 0; c < 20; c++) begin
            wr_tick = (c == 3 || c == 12);
            tick();
        end
        wr_tick = 1'b0;
        wea = 1'b0;
        wait_idle("t2", 400);
        check("t2_rx_n", 32'(rx_q.size()), 32'd2);
        check("t2_rx0", rx_at(0), 32'h55);
        check("t2_rx1", rx_at(1), 32'h55);
        rx_q.delete();

        // 3: overflow on the sixth back-to-back push, then clear
        for (int i = 1; i <= 5; i++) store(A_TX, 32'(i));
        check("t3_ovf_before", 32'(overflow), 32'd0);
        store(A_TX, 32'h06);
        check("t3_ovf_set", 32'(overflow), 32'd1);
        tick();
        check("t3_ovf_sticky", 32'(overflow), 32'd1);
        store(A_CLR, 32'h0);
        check("t3_ovf_clr", 32'(overflow), 32'd0);
        wait_idle("t3", 1000);
        check("t3_rx_n", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) check($sformatf("t3_rx%0d", i), rx_at(i), 32'(i + 1));
        rx_q.delete();

        // 4: LED register and ignored accesses
        store(A_LED, 32'h1234_56A5);
        check("t4_led", 32'(led), 32'hA5);
        store(32'h0000_9000, 32'h3C);
        check("t4_led_unmapped", 32'(led), 32'hA5);
        m_addr = A_LED;
        m_data = 32'h5A;
        wea = 1'b1;
        repeat (3) tick();
        wea = 1'b0;
        check("t4_led_no_tick", 32'(led), 32'hA5);
        wr_tick = 1'b1;
        tick();
        wr_tick = 1'b0;
        check("t4_led_no_wea", 32'(led), 32'hA5);
        check("t4_busy", 32'(busy), 32'd0);

        // 5: reset mid-frame with bytes queued
        store(A_TX, 32'h11);
        store(A_TX, 32'h22);
        store(A_TX, 32'h33);
        repeat (10) tick();
        check("t5_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_tx", 32'(tx), 32'd1);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_led", 32'(led), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (150) tick();
        check("t5_busy_post", 32'(busy), 32'd0);
        check("t5_tx_post", 32'(tx), 32'd1);
        check("t5_rx_n", 32'(rx_q.size()), 32'd0);

`ifdef MMIO_UART_PARITY_EN
        // 6: parity bit values
        store(A_TX, 32'h07);
        expect_frame("t6a", 8'h07);
        store(A_TX, 32'h03);
        expect_frame("t6b", 8'h03);
`endif

        check("rx_framing_errors", 32'(rx_err), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
